imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder: the slave end of the imem fetch bus driven by the fetch unit.
- Accepts one line request at a time and returns one aligned line of `BUS_LEN 32-bit words on imem_rdata after a configurable latency.
- Flags out-of-range addresses with imem_err.
- Used as the instruction memory in SoC simulation and FPGA builds.
- A backdoor load port fills the array before or during run.

Parameters:
- MEM_BASE, 'h0, byte address of array word 0; aligned to 4*`BUS_LEN.
- MEM_WORDS, 4096, array depth in 32-bit words; must be a multiple of `BUS_LEN.
- LATENCY, 1, cycles from acceptance to imem_resp; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- imem_req  in  1  line request.
- imem_addr  in  `XLEN  request byte address.
- imem_rdata  out  `BUS_WID  returned line; word k sits at bits [32k+31:32k].
- imem_resp  out  1  response strobe, one cycle per accepted request.
- imem_err  out  1  error qualifier, valid only with imem_resp.
- load_vld  in  1  backdoor write strobe.
- load_addr  in  `XLEN  backdoor byte address (word-aligned; bits [1:0] ignored).
- load_data  in  32  backdoor write data.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=0 at a clk edge):
  - imem_resp=0, imem_err=0, imem_rdata=0, proto_err=0.
  - State goes to IDLE; any outstanding request is dropped with no response.
  - Array contents are not cleared.
- Line address: imem_addr with low log2(4*`BUS_LEN) bits forced to 0.
- In range: MEM_BASE <= line address < MEM_BASE + 4*MEM_WORDS.
- States:
  - IDLE: no request outstanding.
  - BUSY: a request is outstanding; down-counter cnt is running.
- Acceptance: imem_req=1 while in IDLE, or in the BUSY cycle where imem_resp=1.
  - On acceptance: latch line address and range flag, load cnt=LATENCY-1, go to BUSY.
- BUSY with cnt!=0: decrement cnt each cycle.
- BUSY with cnt==0:
  - Drive imem_resp=1 combinationally in this cycle.
  - imem_rdata = array words at the latched address; read-before-write if load_vld hits the same word this cycle.
  - imem_err = ~range flag. When imem_err=1, imem_rdata=0.
  - Next state: BUSY (re-accept) if imem_req=1 this cycle, else IDLE.
- Back-to-back: with LATENCY=1 and imem_req held high, imem_resp is high every cycle from the cycle after the first request.
- Outside response cycles: imem_rdata=0, imem_err=0.
- Every accepted request gets exactly one response, including requests the initiator has since abandoned after a jump.
- Protocol violation: imem_req=1 in BUSY with imem_resp=0.
  - The request is ignored; proto_err is set and holds until reset.
- Backdoor load: load_vld writes load_data to word (load_addr-MEM_BASE)>>2 at the clk edge.
  - An out-of-range write is dropped silently.
  - Writes are accepted in any state, including during reset.

Optional Feature:
- Macro: IMEM_RESPONDER_STALL_EN.
- Defined:
  - 8-bit LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset, advanced once per acceptance.
  - On acceptance, cnt loads LATENCY-1+lfsr[1:0] (0-3 extra wait cycles), using the LFSR value before the advance.
  - This exercises initiator stall handling.
- Not defined: latency is exactly LATENCY; no LFSR logic is present.

Test Plan (`BUS_LEN=2, MEM_BASE='h0, MEM_WORDS=1024):
- Load word 'h80='h11111111 and 'h84='h22222222; LATENCY=1; imem_req at cycle 0 with addr 'h84 -> cycle 1: imem_resp=1, imem_err=0, imem_rdata=64'h22222222_11111111 (address aligned down to 'h80).
- LATENCY=3; one request at cycle 0 -> imem_resp=1 only in cycle 3; imem_resp=0 in cycles 1, 2, 4.
- LATENCY=1; imem_req held high for addrs 'h0,'h8,'h10,'h18 -> imem_resp=1 in cycles 1-4 with lines in order; proto_err=0.
- Request addr 'h1000 (one past the array end) -> imem_resp=1, imem_err=1, imem_rdata=0; the next request to 'h0 responds with imem_err=0.
- LATENCY=3; request at cycle 0, second imem_req at cycle 1 -> proto_err=1 from cycle 2; exactly one imem_resp, in cycle 3.
- Request at cycle 0 with LATENCY=3, rst=0 at cycle 2 -> no imem_resp in cycles 2-6; after rst=1 a new request responds normally.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory slave that returns one aligned `BUS_LEN-word line per accepted request.
// Optional macro IMEM_RESPONDER_STALL_EN adds 0-3 LFSR-driven wait cycles to every request.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_LEN
`define BUS_LEN 2
`endif
`ifndef BUS_WID
`define BUS_WID (32*`BUS_LEN)
`endif

module imem_responder #(
    parameter logic [`XLEN-1:0] MEM_BASE  = '0,
    parameter int unsigned      MEM_WORDS = 4096,
    parameter int unsigned      LATENCY   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_req,
    input  logic [`XLEN-1:0]    imem_addr,
    output logic [`BUS_WID-1:0] imem_rdata,
    output logic                imem_resp,
    output logic                imem_err,
    input  logic                load_vld,
    input  logic [`XLEN-1:0]    load_addr,
    input  logic [31:0]         load_data,
    output logic                proto_err
);
    localparam int unsigned XW         = `XLEN;
    localparam int unsigned XW1        = XW + 1;
    localparam int unsigned BL         = `BUS_LEN;
    localparam int unsigned LINE_BYTES = 4 * BL;
    localparam int unsigned AW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CW         = $clog2(LATENCY + 4);
    localparam logic [XW-1:0] LINE_MASK = ~XW'(LINE_BYTES - 1);
    localparam logic [XW:0]   MEM_LO    = {1'b0, MEM_BASE};
    localparam logic [XW:0]   SPAN      = XW1'(4 * MEM_WORDS);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XW-1:0]   r_line;
    logic            r_in_range;
    logic            r_proto_err;
    logic [31:0]     r_mem [MEM_WORDS];

    logic [XW-1:0]       w_line;
    logic                w_in_range;
    logic                w_resp;
    logic                w_accept;
    logic                w_viol;
    logic                w_load_hit;
    logic [AW-1:0]       w_ld_idx;
    logic [AW-1:0]       w_rd_base;
    logic [CW-1:0]       w_cnt_init;
    logic [`BUS_WID-1:0] w_line_data;

    // Offsets below the base wrap into the top bit, so one unsigned compare covers both bounds.
    assign w_line     = imem_addr & LINE_MASK;
    assign w_in_range = (({1'b0, w_line} - MEM_LO) < SPAN);
    assign w_resp     = rst && (r_state == S_BUSY) && (r_cnt == '0);
    assign w_accept   = imem_req && ((r_state == S_IDLE) || w_resp);
    assign w_viol     = imem_req && (r_state == S_BUSY) && !w_resp;

    assign w_load_hit = load_vld && (({1'b0, load_addr} - MEM_LO) < SPAN);
    assign w_ld_idx   = AW'(({1'b0, load_addr} - MEM_LO) >> 2);
    assign w_rd_base  = AW'((r_line - MEM_BASE) >> 2);

`ifdef IMEM_RESPONDER_STALL_EN
    logic [7:0] r_lfsr;

    // x^8+x^6+x^5+x^4+1; the pre-advance value picks this request's extra wait.
    assign w_cnt_init = CW'(LATENCY - 1) + CW'(r_lfsr[1:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lfsr <= 8'hA5;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end
`else
    assign w_cnt_init = CW'(LATENCY - 1);
`endif

    // Request FSM: accept in IDLE or in the response cycle, count down while BUSY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_line      <= '0;
            r_in_range  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_viol) begin
                r_proto_err <= 1'b1;
            end
            if (w_accept) begin
                r_state    <= S_BUSY;
                r_cnt      <= w_cnt_init;
                r_line     <= w_line;
                r_in_range <= w_in_range;
            end else if (r_state == S_BUSY) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end else begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    // Backdoor port writes regardless of reset or FSM state.
    always_ff @(posedge clk) begin
        if (w_load_hit) begin
            r_mem[w_ld_idx] <= load_data;
        end
    end

    for (genvar k = 0; k < BL; k++) begin : g_word
        assign w_line_data[32*k +: 32] = r_mem[w_rd_base + AW'(k)];
    end

    assign imem_resp  = w_resp;
    assign imem_err   = w_resp && !r_in_range;
    assign imem_rdata = (w_resp && r_in_range) ? w_line_data : '0;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed vector table plus randomized traffic against a due-cycle queue model,
// using one LATENCY=1 and one LATENCY=3 instance sharing the backdoor load port.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_LEN
`define BUS_LEN 2
`endif
`ifndef BUS_WID
`define BUS_WID (32*`BUS_LEN)
`endif

module tb_imem_responder;
    localparam int unsigned MEM_W = 1024;
    localparam int unsigned BL    = `BUS_LEN;
    localparam int unsigned DW    = 32 * BL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst1, rst3, req1, req3, load_vld;
    logic [31:0]   addr1, addr3, load_addr, load_data;
    logic [DW-1:0] rdata1, rdata3;
    logic          resp1, resp3, err1, err3, perr1, perr3;

    imem_responder #(.MEM_BASE(32'h0), .MEM_WORDS(MEM_W), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst1), .imem_req(req1), .imem_addr(addr1),
        .imem_rdata(rdata1), .imem_resp(resp1), .imem_err(err1),
        .load_vld(load_vld), .load_addr(load_addr), .load_data(load_data),
        .proto_err(perr1)
    );

    imem_responder #(.MEM_BASE(32'h0), .MEM_WORDS(MEM_W), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3), .imem_req(req3), .imem_addr(addr3),
        .imem_rdata(rdata3), .imem_resp(resp3), .imem_err(err3),
        .load_vld(load_vld), .load_addr(load_addr), .load_data(load_data),
        .proto_err(perr3)
    );

    logic [31:0] model_mem [MEM_W];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int            sel;
        logic          req;
        logic [31:0]   addr;
        logic          exp_resp;
        logic          exp_err;
        logic [DW-1:0] exp_data;
        logic          exp_perr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input int s, input logic r, input logic [31:0] a, input logic er,
                                input logic ee, input logic [DW-1:0] ed, input logic ep);
        vec_t v;
        v.sel = s; v.req = r; v.addr = a; v.exp_resp = er; v.exp_err = ee; v.exp_data = ed; v.exp_perr = ep;
        return v;
    endfunction

    function automatic logic [DW-1:0] line_of(input logic [31:0] a);
        logic [DW-1:0] v;
        int w;
        w = int'((a & ~32'(4 * BL - 1)) >> 2);
        for (int k = 0; k < int'(BL); k++) v[32*k +: 32] = model_mem[w + k];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check(input int s, input string nm, input logic er, input logic ee,
                         input logic [DW-1:0] ed, input logic ep);
        chk({nm, " resp"},  DW'(s == 1 ? resp1 : resp3), DW'(er));
        chk({nm, " err"},   DW'(s == 1 ? err1 : err3),   DW'(ee));
        chk({nm, " rdata"}, (s == 1) ? rdata1 : rdata3,  ed);
        chk({nm, " proto"}, DW'(s == 1 ? perr1 : perr3), DW'(ep));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int s, input logic r, input logic [31:0] a);
        if (s == 1) begin req1 = r; addr1 = a; end
        else        begin req3 = r; addr3 = a; end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_vld = 1'b1; load_addr = a; load_data = d;
        if (a < 32'(4 * MEM_W)) model_mem[a >> 2] = d;
        next_cycle();
        load_vld = 1'b0;
    endtask

    // Reference: an accepted request is due exactly `lat` cycles later; a request while waiting is a violation.
    task automatic rand_run(input int s, input int lat, input int n, input bit legal_only);
        bit have = 0;
        bit perr = 0;
        int due = 0;
        logic [31:0] line = '0;
        logic r, lv, exp_resp, exp_err, inr;
        logic [31:0] a, la, ld;
        logic [DW-1:0] exp_data;
        for (int c = 0; c < n + 4; c++) begin
            r = (c < n) && ($urandom_range(0, 3) != 0);
            if (legal_only && have && due != c) r = 1'b0;
            case ($urandom_range(0, 9))
                0:       a = 32'h1000 + 32'($urandom_range(0, 255));
                1:       a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: a = 32'($urandom_range(0, 255));
            endcase
            lv = ($urandom_range(0, 2) == 0);
            la = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'(4 * $urandom_range(0, 63))
                                             : 32'(4 * $urandom_range(0, 63) + $urandom_range(0, 3));
            ld = $urandom;
            drive_req(s, r, a);
            load_vld = lv; load_addr = la; load_data = ld;
            exp_resp = have && (due == c);
            inr      = line < 32'(4 * MEM_W);
            exp_err  = exp_resp && !inr;
            exp_data = (exp_resp && inr) ? line_of(line) : '0;
            @(negedge clk);
            check(s, $sformatf("rand%0d c%0d", s, c), exp_resp, exp_err, exp_data, perr);
            if (r && have && !exp_resp) perr = 1;
            if (r && (!have || exp_resp)) begin
                have = 1; due = c + lat; line = a & ~32'(4 * BL - 1);
            end else if (exp_resp) begin
                have = 0;
            end
            if (lv && la < 32'(4 * MEM_W)) model_mem[la >> 2] = ld;
            next_cycle();
        end
        drive_req(s, 1'b0, '0);
        load_vld = 1'b0;
    endtask

    initial begin
        rst1 = 1'b0; rst3 = 1'b0; req1 = 1'b0; req3 = 1'b0; addr1 = '0; addr3 = '0;
        load_vld = 1'b0; load_addr = '0; load_data = '0;

        // Fill the whole array while both instances sit in reset.
        for (int i = 0; i < int'(MEM_W); i++) begin
            load_vld = 1'b1; load_addr = 32'(4 * i); load_data = $urandom;
            model_mem[i] = load_data;
            next_cycle();
        end
        load_vld = 1'b0;
        @(negedge clk);
        check(1, "reset1", 1'b0, 1'b0, '0, 1'b0);
        check(3, "reset3", 1'b0, 1'b0, '0, 1'b0);
        next_cycle();

        do_load(32'h80, 32'h1111_1111);
        do_load(32'h84, 32'h2222_2222);
        rst1 = 1'b1; rst3 = 1'b1;
        next_cycle();

        // aligned-down line, LATENCY=1
        vt.push_back(mk(1, 1, 32'h84, 0, 0, '0, 0));
        vt.push_back(mk(1, 0, 32'h0,  1, 0, 64'h2222_2222_1111_1111, 0));
        vt.push_back(mk(1, 0, 32'h0,  0, 0, '0, 0));
        // back-to-back stream
        vt.push_back(mk(1, 1, 32'h0,  0, 0, '0, 0));
        vt.push_back(mk(1, 1, 32'h8,  1, 0, line_of(32'h0), 0));
        vt.push_back(mk(1, 1, 32'h10, 1, 0, line_of(32'h8), 0));
        vt.push_back(mk(1, 1, 32'h18, 1, 0, line_of(32'h10), 0));
        vt.push_back(mk(1, 0, 32'h0,  1, 0, line_of(32'h18), 0));
        vt.push_back(mk(1, 0, 32'h0,  0, 0, '0, 0));
        // one past the end, then re-accept 'h0 in the error response cycle
        vt.push_back(mk(1, 1, 32'h1000, 0, 0, '0, 0));
        vt.push_back(mk(1, 1, 32'h0,    1, 1, '0, 0));
        vt.push_back(mk(1, 0, 32'h0,    1, 0, line_of(32'h0), 0));
        vt.push_back(mk(1, 0, 32'h0,    0, 0, '0, 0));
        // LATENCY=3 single request
        vt.push_back(mk(3, 1, 32'h44, 0, 0, '0, 0));
        vt.push_back(mk(3, 0, 32'h0,  0, 0, '0, 0));
        vt.push_back(mk(3, 0, 32'h0,  0, 0, '0, 0));
        vt.push_back(mk(3, 0, 32'h0,  1, 0, line_of(32'h40), 0));
        vt.push_back(mk(3, 0, 32'h0,  0, 0, '0, 0));
        // request while busy is ignored and sets the sticky flag
        vt.push_back(mk(3, 1, 32'h20, 0, 0, '0, 0));
        vt.push_back(mk(3, 1, 32'h28, 0, 0, '0, 0));
        vt.push_back(mk(3, 0, 32'h0,  0, 0, '0, 1));
        vt.push_back(mk(3, 0, 32'h0,  1, 0, line_of(32'h20), 1));
        vt.push_back(mk(3, 0, 32'h0,  0, 0, '0, 1));
        vt.push_back(mk(3, 0, 32'h0,  0, 0, '0, 1));

        foreach (vt[i]) begin
            drive_req(vt[i].sel, vt[i].req, vt[i].addr);
            @(negedge clk);
            check(vt[i].sel, $sformatf("vec%0d", i), vt[i].exp_resp, vt[i].exp_err,
                  vt[i].exp_data, vt[i].exp_perr);
            next_cycle();
        end
        drive_req(1, 1'b0, '0);
        drive_req(3, 1'b0, '0);

        // Reset two cycles into a LATENCY=3 request drops it; a load during reset still lands.
        drive_req(3, 1'b1, 32'h30);
        @(negedge clk); check(3, "rst c0", 1'b0, 1'b0, '0, 1'b1);
        next_cycle();
        drive_req(3, 1'b0, '0);
        @(negedge clk); check(3, "rst c1", 1'b0, 1'b0, '0, 1'b1);
        next_cycle();
        rst3 = 1'b0; load_vld = 1'b1; load_addr = 32'h38; load_data = 32'hCAFE_F00D;
        @(negedge clk); check(3, "rst c2", 1'b0, 1'b0, '0, 1'b1);
        model_mem[32'h38 >> 2] = 32'hCAFE_F00D;
        next_cycle();
        rst3 = 1'b1; load_vld = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk); check(3, $sformatf("rst c%0d", c), 1'b0, 1'b0, '0, 1'b0);
            next_cycle();
        end
        for (int c = 7; c <= 11; c++) begin
            drive_req(3, c == 7, 32'h38);
            @(negedge clk);
            check(3, $sformatf("rst c%0d", c), c == 10, 1'b0, (c == 10) ? line_of(32'h38) : '0, 1'b0);
            next_cycle();
        end
        drive_req(3, 1'b0, '0);

        rand_run(1, 1, 400, 1'b0);
        rand_run(3, 3, 400, 1'b1);
        rand_run(3, 3, 100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
